// File: rtl/cook_if.sv
// Keypad/front-end to cook sequencer bus: control pulses, entry fields and status.
// start/stop are single-cycle pulses sampled on clk; door_open is a level; no ready path.
interface cook_if #(
  parameter int MIN_W = 7,
  parameter int PW    = 3
);
  logic             start;
  logic             stop;
  logic             door_open;
  logic [MIN_W-1:0] time_min;
  logic [5:0]       time_sec;
  logic [PW-1:0]    power_level;
  logic             cooking;
  logic             mag_control;
  logic             buzzer;
  logic [MIN_W-1:0] remaining_min;
  logic [5:0]       remaining_sec;
  logic [1:0]       state;

  modport master (
    output start, stop, door_open, time_min, time_sec, power_level,
    input  cooking, mag_control, buzzer, remaining_min, remaining_sec, state
  );

  modport slave (
    input  start, stop, door_open, time_min, time_sec, power_level,
    output cooking, mag_control, buzzer, remaining_min, remaining_sec, state
  );
endinterface

// File: rtl/cook_sequencer.sv
// Minutes:seconds cook timer with power-level duty window, +30 s, pause/cancel,
// door interlock on the magnetron and a timed end-of-cook buzzer.
module cook_sequencer #(
  parameter int CLK_PER_SEC = 1_000_000,
  parameter int MIN_W       = 7,
  parameter int MAX_MIN     = 99,
  parameter int PW          = 3,
  parameter int BUZZ_SEC    = 3
) (
  input  logic  clk,
  input  logic  rst,
  cook_if.slave bus
);
  localparam int PMAX  = (1 << PW) - 1;
  localparam int PRE_W = $clog2(CLK_PER_SEC);
  localparam int BZ_W  = $clog2(BUZZ_SEC + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e           state_q;
  logic [MIN_W-1:0] rem_min_q;
  logic [5:0]       rem_sec_q;
  logic [PRE_W-1:0] presc_q;
  logic [PW-1:0]    win_q;
  logic [BZ_W-1:0]  buzz_q;

  logic             tick;
  logic [MIN_W-1:0] entry_min, base_min, rem_min_d;
  logic [5:0]       entry_sec, base_sec, rem_sec_d;
  logic [6:0]       sec_plus;
  logic [PW-1:0]    win_d;
  logic             entry_zero;

  always_comb begin
    tick       = (presc_q == PRE_W'(CLK_PER_SEC - 1));
    entry_min  = (bus.time_min > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : bus.time_min;
    entry_sec  = (bus.time_sec > 6'd59) ? 6'd59 : bus.time_sec;
    entry_zero = (entry_min == '0) && (entry_sec == '0);
    // Countdown first, then any +30 s lands on top of the decremented value.
    base_min = rem_min_q;
    base_sec = rem_sec_q;
    if (tick) begin
      if (rem_sec_q == 6'd0) begin
        base_min = rem_min_q - 1'b1;
        base_sec = 6'd59;
      end else begin
        base_sec = rem_sec_q - 1'b1;
      end
    end
    sec_plus  = {1'b0, base_sec} + 7'd30;
    rem_min_d = base_min;
    rem_sec_d = base_sec;
    if (bus.start) begin
      if (sec_plus < 7'd60) begin
        rem_sec_d = sec_plus[5:0];
      end else if (base_min == MIN_W'(MAX_MIN)) begin
        rem_sec_d = 6'd59;
      end else begin
        rem_min_d = base_min + 1'b1;
        rem_sec_d = 6'(sec_plus - 7'd60);
      end
    end
    win_d = win_q;
    if (tick) win_d = (win_q == PW'(PMAX - 1)) ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_min_q <= '0;
      rem_sec_q <= '0;
      presc_q   <= '0;
      win_q     <= '0;
      buzz_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.stop && !bus.door_open && !entry_zero) begin
            state_q   <= ST_COOKING;
            rem_min_q <= entry_min;
            rem_sec_q <= entry_sec;
            presc_q   <= '0;
            win_q     <= '0;
          end
        end
        ST_COOKING: begin
          if (bus.stop || bus.door_open) begin
            state_q <= ST_PAUSED;
          end else begin
            presc_q   <= tick ? '0 : presc_q + 1'b1;
            win_q     <= win_d;
            rem_min_q <= rem_min_d;
            rem_sec_q <= rem_sec_d;
            if (rem_min_d == '0 && rem_sec_d == '0) state_q <= ST_DONE;
          end
        end
        ST_PAUSED: begin
          if (bus.stop) begin
            state_q   <= ST_IDLE;
            rem_min_q <= '0;
            rem_sec_q <= '0;
            presc_q   <= '0;
            win_q     <= '0;
          end else if (bus.start && !bus.door_open) begin
            state_q <= ST_COOKING;
          end
        end
        ST_DONE: begin
          if (bus.stop || bus.start || bus.door_open) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            buzz_q  <= '0;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
              if (buzz_q == BZ_W'(BUZZ_SEC - 1)) begin
                state_q <= ST_IDLE;
                buzz_q  <= '0;
              end else begin
                buzz_q <= buzz_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Door gating is combinational so the magnetron drops in the cycle the door opens.
  assign bus.mag_control   = (state_q == ST_COOKING) && (win_q < bus.power_level) && !bus.door_open;
  assign bus.cooking       = (state_q == ST_COOKING);
  assign bus.buzzer        = (state_q == ST_DONE);
  assign bus.remaining_min = rem_min_q;
  assign bus.remaining_sec = rem_sec_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer with a 4-cycle second and 3 s buzzer.
module tb_cook_sequencer;
  localparam int CPS      = 4;
  localparam int MIN_W    = 7;
  localparam int MAX_MIN  = 99;
  localparam int PW       = 3;
  localparam int BUZZ_SEC = 3;
  localparam int W        = 18;

  logic clk = 1'b0;
  logic rst;

  cook_if #(.MIN_W(MIN_W), .PW(PW)) bus ();

  cook_sequencer #(
    .CLK_PER_SEC(CPS),
    .MIN_W      (MIN_W),
    .MAX_MIN    (MAX_MIN),
    .PW         (PW),
    .BUZZ_SEC   (BUZZ_SEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic mag,
                                       input logic [MIN_W-1:0] mn, input logic [5:0] sc);
    return {st, st == 2'd1, mag, st == 2'd3, mn, sc};
  endfunction

  function automatic logic [W-1:0] obs();
    return {bus.state, bus.cooking, bus.mag_control, bus.buzzer,
            bus.remaining_min, bus.remaining_sec};
  endfunction

  task automatic expect_obs(input logic [1:0] st, input logic mag,
                            input logic [MIN_W-1:0] mn, input logic [5:0] sc);
    exp_q.push_back(mk(st, mag, mn, sc));
  endtask

  task automatic compare(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got 0x%0h expected <empty queue>", tag, obs());
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(obs()), 32'(e));
    end
  endtask

  // Drivers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  task automatic set_entry(input int mn, input int sc, input int pw);
    bus.time_min    = MIN_W'(mn);
    bus.time_sec    = 6'(sc);
    bus.power_level = PW'(pw);
  endtask

  task automatic run_ext(input int mn, input int sc, input int emn, input int esc, input string tag);
    set_entry(mn, sc, 7);
    pulse_start();
    pulse_start();
    expect_obs(2'd1, 1'b1, MIN_W'(emn), 6'(esc));
    compare(tag);
    pulse_stop();
    pulse_stop();
  endtask

  int  cnt, on, errs;
  logic mag_all, any_on, exp_mag;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.door_open = 1'b0;
    set_entry(0, 3, 7);
    step(2);
    rst = 1'b0;
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("reset");

    // Full run 0:03 at full power, then buzzer
    pulse_start();
    cnt = 0;
    mag_all = 1'b1;
    while (bus.cooking && cnt < 100) begin
      cnt++;
      if (!bus.mag_control) mag_all = 1'b0;
      step(1);
    end
    chk("cook_cycles", cnt, 12);
    chk("mag_full_power", mag_all, 1);
    expect_obs(2'd3, 1'b0, 0, 0);
    compare("done_entry");
    cnt = 0;
    while (bus.buzzer && cnt < 100) begin
      cnt++;
      step(1);
    end
    chk("buzz_cycles", cnt, 12);
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("idle_after_done");

    // 1:00 countdown, pause and cancel, refused starts
    set_entry(1, 0, 7);
    pulse_start();
    expect_obs(2'd1, 1'b1, 1, 0);
    compare("load_1_00");
    step(4);
    expect_obs(2'd1, 1'b1, 0, 59);
    compare("first_tick_0_59");
    pulse_stop();
    expect_obs(2'd2, 1'b0, 0, 59);
    compare("stop_pauses");
    pulse_stop();
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("stop_paused_idle");
    set_entry(0, 0, 7);
    pulse_start();
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("zero_entry");
    set_entry(0, 5, 7);
    bus.door_open = 1'b1;
    pulse_start();
    bus.door_open = 1'b0;
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("start_door_open_idle");

    // Power 3 duty pattern over two windows
    set_entry(0, 14, 3);
    pulse_start();
    errs = 0;
    on = 0;
    for (int k = 0; k < 56; k++) begin
      exp_mag = (((k / CPS) % 7) < 3);
      if (bus.mag_control !== exp_mag) errs++;
      if (k < 28 && bus.mag_control) on++;
      step(1);
    end
    chk("duty_p3_errs", errs, 0);
    chk("duty_p3_on_cycles", on, 12);
    expect_obs(2'd3, 1'b0, 0, 0);
    compare("done_p3");
    pulse_stop();
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("stop_done_idle");

    // Power 0 never drives the magnetron
    set_entry(0, 2, 0);
    pulse_start();
    any_on = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mag_control) any_on = 1'b1;
      step(1);
    end
    chk("mag_p0", any_on, 0);
    expect_obs(2'd3, 1'b0, 0, 0);
    compare("done_p0");
    bus.door_open = 1'b1;
    step(1);
    bus.door_open = 1'b0;
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("door_done_idle");

    // Door interlock mid-cook, ignored start, resume
    set_entry(0, 3, 7);
    pulse_start();
    on = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mag_control) on++;
      step(1);
    end
    bus.door_open = 1'b1;
    #1;
    expect_obs(2'd1, 1'b0, 0, 2);
    compare("door_same_cycle");
    step(1);
    expect_obs(2'd2, 1'b0, 0, 2);
    compare("door_paused");
    step(3);
    pulse_start();
    expect_obs(2'd2, 1'b0, 0, 2);
    compare("start_door_ignored");
    bus.door_open = 1'b0;
    pulse_start();
    expect_obs(2'd1, 1'b1, 0, 2);
    compare("resume");
    cnt = 0;
    while (bus.cooking && cnt < 100) begin
      cnt++;
      if (bus.mag_control) on++;
      step(1);
    end
    chk("door_total_mag", on, 12);
    expect_obs(2'd3, 1'b0, 0, 0);
    compare("done_after_resume");
    pulse_start();
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("start_done_idle");

    // +30 s extension and entry clamping
    run_ext(98, 45, 99, 15, "ext_98_45");
    run_ext(99, 50, 99, 59, "ext_sat_99_50");
    run_ext(0, 40, 1, 10, "ext_0_40");
    run_ext(0, 10, 0, 40, "ext_0_10");
    set_entry(120, 63, 7);
    pulse_start();
    expect_obs(2'd1, 1'b1, 99, 59);
    compare("entry_clamp");
    pulse_stop();
    pulse_stop();

    // Reset while cooking
    set_entry(0, 5, 7);
    pulse_start();
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("rst_mid_cook");

    // stop, door and start together while cooking
    pulse_start();
    step(2);
    bus.start     = 1'b1;
    bus.stop      = 1'b1;
    bus.door_open = 1'b1;
    step(1);
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.door_open = 1'b0;
    expect_obs(2'd2, 1'b0, 0, 5);
    compare("all_events_pause");
    pulse_stop();
    expect_obs(2'd0, 1'b0, 0, 0);
    compare("final_idle");

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
